// File: rtl/clk_gate_ctrl.sv
`timescale 1ns/1ps
// clk_gate_ctrl: request-driven clock-gate sequencer with wake delay, idle hysteresis and a divided enable strobe.
// Define CLK_GATE_CTRL_STATS_EN to add the wake_count / on_cycles usage statistics ports.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 8,
  parameter int IDLE_CYCLES = 16,
  parameter int DIV_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  input  logic [DIV_W-1:0]   div_ratio,
  output logic               gate_en,
  output logic               clk_en_strobe,
  output logic               busy,
  output logic [1:0]         dbg_state
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  output logic [15:0]        wake_count,
  output logic [31:0]        on_cycles
`endif
);

  // req/ack are level-based: a requester holds req[i] while it needs the clock;
  // ack[i] is high only in ON, one cycle after req[i] is seen there, and drops one cycle after req[i] drops.

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int ICW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYCLES - 1);
  localparam logic [ICW-1:0] IDLE_LOAD = ICW'(IDLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [WCW-1:0]     wake_cnt_q;
  logic [ICW-1:0]     idle_cnt_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               gate_en_q;
  logic               strobe_q;
  logic               any_req;
  logic               div_wrap;
  logic               run_q;
  logic               run_d;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [15:0]        wake_count_q;
  logic [31:0]        on_cycles_q;
`endif

  always_comb begin
    any_req  = |req;
    div_wrap = (div_cnt_q == (div_q - DIV_W'(1)));
    state_d  = state_q;
    case (state_q)
      ST_OFF:  if (any_req) state_d = ST_WAKE;
      ST_WAKE: if (wake_cnt_q == '0) state_d = ST_ON;
      ST_ON:   if (!any_req) state_d = ST_IDLE;
      ST_IDLE: begin
        // A request in the last hysteresis cycle wins over gating off.
        if (any_req)                 state_d = ST_ON;
        else if (idle_cnt_q == '0)   state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
    run_q = (state_q == ST_ON) || (state_q == ST_IDLE);
    run_d = (state_d == ST_ON) || (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_OFF;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      div_q      <= DIV_W'(1);
      div_cnt_q  <= '0;
      ack_q      <= '0;
      gate_en_q  <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_en_q <= (state_d != ST_OFF);
      ack_q     <= (state_q == ST_ON) ? req : '0;

      case (state_q)
        ST_OFF: begin
          if (any_req) begin
            wake_cnt_q <= WAKE_LOAD;
            div_q      <= (div_ratio == '0) ? DIV_W'(1) : div_ratio;
          end
        end
        ST_WAKE: begin
          if (wake_cnt_q != '0) wake_cnt_q <= wake_cnt_q - WCW'(1);
        end
        ST_ON: begin
          if (!any_req) idle_cnt_q <= IDLE_LOAD;
        end
        ST_IDLE: begin
          if (!any_req && (idle_cnt_q != '0)) idle_cnt_q <= idle_cnt_q - ICW'(1);
        end
        default: ;
      endcase

      // Divider phase starts fresh on every wake; IDLE->ON re-entry keeps it running.
      if (run_q) div_cnt_q <= div_wrap ? '0 : div_cnt_q + DIV_W'(1);
      else       div_cnt_q <= '0;

      strobe_q <= run_q && run_d && div_wrap;
    end
  end

`ifdef CLK_GATE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wake_count_q <= '0;
      on_cycles_q  <= '0;
    end else begin
      if ((state_q == ST_OFF) && (state_d == ST_WAKE) && (wake_count_q != 16'hFFFF))
        wake_count_q <= wake_count_q + 16'd1;
      if (gate_en_q && (on_cycles_q != 32'hFFFF_FFFF))
        on_cycles_q <= on_cycles_q + 32'd1;
    end
  end

  assign wake_count = wake_count_q;
  assign on_cycles  = on_cycles_q;
`endif

  assign ack           = ack_q;
  assign gate_en       = gate_en_q;
  assign clk_en_strobe = strobe_q;
  assign busy          = (state_q != ST_OFF);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
`timescale 1ns/1ps
// Directed bench for clk_gate_ctrl: wake latency, idle gating, re-request, divider and async reset.
module tb_clk_gate_ctrl;

  localparam int NUM_REQ = 4;
  localparam int DIV_W   = 8;
  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [DIV_W-1:0]   div_ratio = '0;
  logic [NUM_REQ-1:0] ack;
  logic               gate_en;
  logic               clk_en_strobe;
  logic               busy;
  logic [1:0]         dbg_state;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [15:0]        wake_count;
  logic [31:0]        on_cycles;
`endif

  int tests = 0;
  int fails = 0;
  logic [NUM_REQ-1:0] exp_q[$];

  clk_gate_ctrl #(
    .NUM_REQ(NUM_REQ), .WAKE_CYCLES(8), .IDLE_CYCLES(16), .DIV_W(DIV_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .ack(ack),
    .div_ratio(div_ratio),
    .gate_en(gate_en),
    .clk_en_strobe(clk_en_strobe),
    .busy(busy),
    .dbg_state(dbg_state)
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    .wake_count(wake_count),
    .on_cycles(on_cycles)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == s) break;
      tick();
    end
    chk("wait_state", 32'(dbg_state), 32'(s));
  endtask

  // Caller has req high in OFF; req drops during WAKE, so ON exits straight to IDLE.
  task automatic full_cycle();
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 1) req = '0;
      chk("fc_gate", 32'(gate_en), 32'(c <= 25));
      chk("fc_state", 32'(dbg_state),
          32'((c <= 8) ? S_WAKE : (c == 9) ? S_ON : (c <= 25) ? S_IDLE : S_OFF));
    end
  endtask

  initial begin
    int c;

    // Reset with all requests asserted
    req = 4'hF;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_gate", 32'(gate_en), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_strobe", 32'(clk_en_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_state", 32'(dbg_state), 32'(S_OFF));
    chk("rel_busy", 32'(busy), 32'd0);
    tick();
    chk("rel_wake", 32'(dbg_state), 32'(S_WAKE));
    chk("rel_busy1", 32'(busy), 32'd1);
    req = '0;
    wait_state(S_OFF, 60);

    // Wake latency, ack tracking and divide-by-3 strobe
    req = 4'b0001;
    div_ratio = 8'd3;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("wk_gate", 32'(gate_en), 32'd1);
      chk("wk_ack", 32'(ack), 32'((k == 10) ? 4'b0001 : 4'b0000));
      chk("wk_strobe", 32'(clk_en_strobe), 32'd0);
    end
    exp_q.push_back(req);
    for (c = 11; c <= 40; c++) begin
      tick();
      chk("on_ack", 32'(ack), 32'(exp_q.pop_front()));
      chk("on_strobe3", 32'(clk_en_strobe), 32'((c >= 12) && (((c - 12) % 3) == 0)));
      chk("on_state", 32'(dbg_state), 32'(S_ON));
      if (c == 11) div_ratio = 8'd5;
      req = 4'($urandom_range(1, 15));
      exp_q.push_back(req);
    end

    // Idle hysteresis and gating off
    req = '0;
    void'(exp_q.pop_back());
    exp_q.push_back('0);
    for (c = 41; c <= 57; c++) begin
      tick();
      if (c == 41) chk("idle_ack", 32'(ack), 32'(exp_q.pop_front()));
      chk("idle_gate", 32'(gate_en), 32'(c <= 56));
      chk("idle_strobe", 32'(clk_en_strobe), 32'((c <= 56) && (((c - 12) % 3) == 0)));
    end
    chk("off_busy", 32'(busy), 32'd0);
    chk("off_state", 32'(dbg_state), 32'(S_OFF));

    // Re-request during IDLE with div_ratio 0 (strobe always on)
    req = 4'b0001;
    div_ratio = 8'd0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("rr_gate", 32'(gate_en), 32'd1);
    end
    chk("rr_on", 32'(dbg_state), 32'(S_ON));
    tick();
    chk("rr_ack", 32'(ack), 32'(4'b0001));
    chk("rr_strobe", 32'(clk_en_strobe), 32'd1);
    req = '0;
    for (c = 11; c <= 15; c++) begin
      tick();
      chk("rr_idle", 32'(dbg_state), 32'(S_IDLE));
      chk("rr_idle_ack", 32'(ack), 32'd0);
      chk("rr_idle_strobe", 32'(clk_en_strobe), 32'd1);
    end
    req = 4'b0100;
    exp_q.push_back(req);
    tick();
    chk("rr_reon", 32'(dbg_state), 32'(S_ON));
    chk("rr_reon_ack", 32'(ack), 32'd0);
    chk("rr_reon_gate", 32'(gate_en), 32'd1);
    tick();
    chk("rr_ack2", 32'(ack), 32'(exp_q.pop_front()));
    chk("rr_state2", 32'(dbg_state), 32'(S_ON));
    chk("rr_strobe2", 32'(clk_en_strobe), 32'd1);
    req = '0;
    wait_state(S_OFF, 40);

    // Asynchronous reset in the middle of WAKE
    req = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("ar_wake", 32'(dbg_state), 32'(S_WAKE));
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_gate", 32'(gate_en), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ack", 32'(ack), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    chk("ar_rel", 32'(dbg_state), 32'(S_OFF));

    // Three complete wake/idle cycles from reset
    full_cycle();
    req = 4'b1000;
    full_cycle();
    req = 4'b0001;
    full_cycle();
`ifdef CLK_GATE_CTRL_STATS_EN
    chk("st_wake_count", 32'(wake_count), 32'd3);
    chk("st_on_cycles", on_cycles, 32'd75);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
